// File: rtl/ppm_decoder.sv
// ppm_decoder: pulse-position-modulation frame decoder.
//
// Samples an asynchronous PPM line once per enabled clock (one slot per sample). It reports the
// slot index of the first rising edge in each FRAME_LEN-slot frame, and flags frames that have
// no pulse or more than one pulse. A synchronised sync_in strobe forces its slot to index 0. If
// that happens mid-frame, the running frame is abandoned without a result.
//
// Build option: define PPM_DECODER_GLITCH_FILTER_EN to ignore single-slot highs. A rising edge
// then counts only if the next enabled sample is also high. This adds one slot of latency
// (4 -> 5 enabled edges from the sample of the last slot to out_valid).
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   ena         in   slot enable; when low every register holds
//   ppm_in      in   asynchronous PPM line, active high
//   sync_in     in   asynchronous frame-start strobe
//   pos_out     out  [POS_W-1:0] first-pulse slot of the last completed frame
//   out_valid   out  strobe marking a new frame result
//   err_missing out  last completed frame had no pulse
//   err_multi   out  last completed frame had more than one pulse
module ppm_decoder #(
  parameter int unsigned FRAME_LEN = 256,
  parameter int unsigned POS_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             ppm_in,
  input  logic             sync_in,
  output logic [POS_W-1:0] pos_out,
  output logic             out_valid,
  output logic             err_missing,
  output logic             err_multi
);

  localparam logic [POS_W-1:0] LastSlot = POS_W'(FRAME_LEN - 1);

  // Two-flop synchronisers plus valid bits that mark when real samples reach stage 2
  logic ppm_s1_q, ppm_s2_q, sync_s1_q, sync_s2_q, v1_q, v2_q;
  logic             prev_q;
  logic [POS_W-1:0] cnt_q;

  // Frame accumulator
  logic             found_q, multi_q;
  logic [POS_W-1:0] pos_q;

  // Result, one pipeline stage, then the output registers
  logic             res_valid_q, res_miss_q, res_multi_q;
  logic [POS_W-1:0] res_pos_q;
  logic             p_valid_q, p_miss_q, p_multi_q;
  logic [POS_W-1:0] p_pos_q;

  logic [POS_W-1:0] slot_cur, cnt_nxt;
  logic             rise;

  logic             acc_go, acc_pulse;
  logic [POS_W-1:0] acc_slot;
  logic             base_found, base_multi, nxt_found, nxt_multi, frame_end;
  logic [POS_W-1:0] base_pos, nxt_pos;

  // A synchronised sync forces the slot at stage 2 to 0. In slot 0 of a wrapped frame this
  // changes nothing.
  assign slot_cur = sync_s2_q ? '0 : cnt_q;
  assign cnt_nxt  = (slot_cur == LastSlot) ? '0 : slot_cur + POS_W'(1);
  assign rise     = ppm_s2_q & ~prev_q;

`ifdef PPM_DECODER_GLITCH_FILTER_EN
  // Holds one sample back so that its rising edge can be qualified by the next sample.
  logic             a_valid_q, a_rise_q;
  logic [POS_W-1:0] a_slot_q;

  assign acc_go    = a_valid_q & v2_q;
  assign acc_slot  = a_slot_q;
  assign acc_pulse = a_rise_q & ppm_s2_q;
`else
  assign acc_go    = v2_q;
  assign acc_slot  = slot_cur;
  assign acc_pulse = rise;
`endif

  always_comb begin
    base_found = found_q;
    base_pos   = pos_q;
    base_multi = multi_q;
    // Slot 0 starts a fresh frame and discards any aborted partial frame.
    if (acc_slot == '0) begin
      base_found = 1'b0;
      base_pos   = '0;
      base_multi = 1'b0;
    end
    nxt_found = base_found | acc_pulse;
    nxt_pos   = (acc_pulse && !base_found) ? acc_slot : base_pos;
    nxt_multi = base_multi | (acc_pulse & base_found);
    frame_end = (acc_slot == LastSlot);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ppm_s1_q    <= 1'b0;
      ppm_s2_q    <= 1'b0;
      sync_s1_q   <= 1'b0;
      sync_s2_q   <= 1'b0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      prev_q      <= 1'b1;  // a line already high at reset release is not a pulse
      cnt_q       <= '0;
      found_q     <= 1'b0;
      pos_q       <= '0;
      multi_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_pos_q   <= '0;
      res_miss_q  <= 1'b0;
      res_multi_q <= 1'b0;
      p_valid_q   <= 1'b0;
      p_pos_q     <= '0;
      p_miss_q    <= 1'b0;
      p_multi_q   <= 1'b0;
      out_valid   <= 1'b0;
      pos_out     <= '0;
      err_missing <= 1'b0;
      err_multi   <= 1'b0;
`ifdef PPM_DECODER_GLITCH_FILTER_EN
      a_valid_q   <= 1'b0;
      a_rise_q    <= 1'b0;
      a_slot_q    <= '0;
`endif
    end else if (ena) begin
      ppm_s1_q  <= ppm_in;
      ppm_s2_q  <= ppm_s1_q;
      sync_s1_q <= sync_in;
      sync_s2_q <= sync_s1_q;
      v1_q      <= 1'b1;
      v2_q      <= v1_q;
      if (v2_q) begin
        cnt_q  <= cnt_nxt;
        prev_q <= ppm_s2_q;
      end
`ifdef PPM_DECODER_GLITCH_FILTER_EN
      a_valid_q <= v2_q;
      if (v2_q) begin
        a_slot_q <= slot_cur;
        a_rise_q <= rise;
      end
`endif
      if (acc_go) begin
        found_q <= nxt_found;
        pos_q   <= nxt_pos;
        multi_q <= nxt_multi;
      end
      res_valid_q <= acc_go & frame_end;
      if (acc_go && frame_end) begin
        res_pos_q   <= nxt_found ? nxt_pos : '0;
        res_miss_q  <= ~nxt_found;
        res_multi_q <= nxt_multi;
      end
      p_valid_q <= res_valid_q;
      p_pos_q   <= res_pos_q;
      p_miss_q  <= res_miss_q;
      p_multi_q <= res_multi_q;
      out_valid <= p_valid_q;
      if (p_valid_q) begin
        pos_out     <= p_pos_q;
        err_missing <= p_miss_q;
        err_multi   <= p_multi_q;
      end
    end
  end

endmodule

// File: tb/tb_ppm_decoder.sv
module tb_ppm_decoder;

  localparam int unsigned FrameLen = 256;
  localparam int unsigned PosW     = 8;
`ifdef PPM_DECODER_GLITCH_FILTER_EN
  localparam int Lat  = 5;
  localparam bit Filt = 1'b1;
`else
  localparam int Lat  = 4;
  localparam bit Filt = 1'b0;
`endif
  localparam int MaxLen = 2700;

  logic            clk = 1'b0;
  logic            rst, ena, ppm_in, sync_in;
  logic [PosW-1:0] pos_out;
  logic            out_valid, err_missing, err_multi;

  ppm_decoder #(
    .FRAME_LEN(FrameLen),
    .POS_W    (PosW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .ppm_in     (ppm_in),
    .sync_in    (sync_in),
    .pos_out    (pos_out),
    .out_valid  (out_valid),
    .err_missing(err_missing),
    .err_multi  (err_multi)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pos;
    int miss;
    int multi;
    int edge_n;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   en_edges = 0;

  // Stimulus buffer: one entry per enabled sample, gap[i] disabled cycles before sample i
  bit samp[MaxLen];
  bit sy[MaxLen];
  int gap[MaxLen];
  int n_len;
  bit has_e[MaxLen];
  int e_pos[MaxLen];
  int e_miss[MaxLen];
  int e_multi[MaxLen];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_buf();
    for (int i = 0; i < MaxLen; i++) begin
      samp[i]  = 1'b0;
      sy[i]    = 1'b0;
      gap[i]   = 0;
      has_e[i] = 1'b0;
    end
    n_len = 0;
  endtask

  task automatic pulse(input int at, input int width);
    for (int i = at; i < at + width; i++) samp[i] = 1'b1;
  endtask

  // Frame-level reference: walks the buffer as one run that starts right after reset.
  task automatic model();
    int fstart, cnt, first;
    bit prv, nxt;
    fstart = 0;
    for (int i = 0; i < n_len; i++) begin
      if (sy[i] && i != fstart) fstart = i;
      if (i - fstart == int'(FrameLen) - 1) begin
        cnt   = 0;
        first = 0;
        for (int j = fstart; j <= i; j++) begin
          prv = (j == 0) ? 1'b1 : samp[j-1];
          nxt = (j + 1 < n_len) ? samp[j+1] : 1'b0;
          if (samp[j] && !prv && (!Filt || nxt)) begin
            if (cnt == 0) first = j - fstart;
            cnt++;
          end
        end
        has_e[i]   = 1'b1;
        e_pos[i]   = (cnt == 0) ? 0 : first;
        e_miss[i]  = (cnt == 0) ? 1 : 0;
        e_multi[i] = (cnt > 1) ? 1 : 0;
        fstart     = i + 1;
      end
    end
  endtask

  task automatic drive();
    exp_t e;
    for (int i = 0; i < n_len; i++) begin
      for (int g = 0; g < gap[i]; g++) begin
        ena     = 1'b0;
        ppm_in  = 1'($urandom);
        sync_in = 1'($urandom);
        @(posedge clk);
        #1;
      end
      ena     = 1'b1;
      ppm_in  = samp[i];
      sync_in = sy[i];
      if (has_e[i]) begin
        e.pos    = e_pos[i];
        e.miss   = e_miss[i];
        e.multi  = e_multi[i];
        e.edge_n = en_edges + 1 + Lat;
        sb.push_back(e);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pos"}, 32'(pos_out), 0);
    check({tag, "_valid"}, 32'(out_valid), 0);
    check({tag, "_miss"}, 32'(err_missing), 0);
    check({tag, "_multi"}, 32'(err_multi), 0);
  endtask

  always @(posedge clk) begin
    if (rst) en_edges <= 0;
    else if (ena) en_edges <= en_edges + 1;
  end

  // Scoreboard monitor: only counts out_valid after enabled edges.
  always @(posedge clk) begin
    bit   en_now;
    exp_t e;
    en_now = ena && !rst;
    #1;
    if (en_now && out_valid) begin
      if (sb.size() == 0) begin
        check("spurious_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        check("pos", 32'(pos_out), e.pos);
        check("miss", 32'(err_missing), e.miss);
        check("multi", 32'(err_multi), e.multi);
        check("latency_edge", en_edges, e.edge_n);
      end
    end
  end

  initial begin
    rst     = 1'b1;
    ena     = 1'b1;
    ppm_in  = 1'b1;
    sync_in = 1'b0;

    // Run 1: nine frames of scenarios, then a partial frame cut by reset
    clear_buf();
    pulse(0, 3);                    // high through reset release: not a pulse
    pulse(100, 2);                  // F0 -> 100
    sy[256] = 1'b1;                 // F1 harmless sync on natural slot 0
    pulse(256 + 100, 2);
    gap[256 + 40]  = 3;
    gap[256 + 253] = 2;
    pulse(768 + 7, 2);              // F2 empty, F3 -> 7
    pulse(1024 + 20, 2);            // F4 -> 20 + multi
    pulse(1024 + 200, 2);
    sy[1280 + 50] = 1'b1;           // F5 aborted at slot 50, new frame 1330..1585
    pulse(1280 + 120, 2);           // slot 70 of the new frame
    gap[1587] = 4;                  // disabled cycles inside the result latency window
    pulse(1586 + 255, 3);           // F6 -> 255, held into F7
    sy[2098] = 1'b1;                // F7 missing; F8 slot 0 sync harmless
    pulse(2098 + 30, 1);            // F8 one-slot glitch
    pulse(2362 + 40, 2);            // partial frame, discarded by reset
    n_len = 2362 + 150;
    model();

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst0");
    rst = 1'b0;
    drive();

    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("rst_mid");
    check("sb_empty_mid", sb.size(), 0);

    // Run 2: fresh frame after reset, first enabled edge delayed by ena low
    clear_buf();
    gap[0] = 3;
    pulse(5, 2);
    n_len = 256 + 10;
    model();
    rst = 1'b0;
    drive();

    check("sb_empty_end", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
